muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
Iterative M-extension sequencer for unsigned multiply and divide. It performs the add and subtract steps on the core's shared 32-bit ALU (add = ALUctrl 000, sub = ALUctrl 001) instead of using dedicated arrays. It sits beside the execute stage and drives the ALU operand/control inputs while busy. A start/busy/done handshake lets the core stall until the result is valid.

Parameters:
DATA_WIDTH, 32, operand/result width; also the iteration count.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE or DONE
funct3  input  3  000 MUL (low word), 011 MULHU (high word), 101 DIVU, 111 REMU
rs1  input  DATA_WIDTH  multiplicand / dividend
rs2  input  DATA_WIDTH  multiplier / divisor
alu_op1  output  DATA_WIDTH  operand 1 to the shared ALU
alu_op2  output  DATA_WIDTH  operand 2 to the shared ALU
alu_ctrl  output  3  ALU control (000 add, 001 sub)
alu_sum  input  DATA_WIDTH  ALU result, used combinationally in the same cycle
busy  output  1  operation in progress; the ALU is owned by this block
done  output  1  one-cycle pulse; result valid
result  output  DATA_WIDTH  final value; held until the next accepted start

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
  - Reset mid-operation aborts immediately; no done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1, legal funct3, non-zero divisor (or a multiply): latch the operands, counter=0, go to RUN.
  - IDLE, start=1, DIVU/REMU with rs2=0: go directly to DONE. DIVU result = all ones; REMU result = rs1.
  - IDLE, start=1, illegal funct3 (001, 010, 100, 110): go directly to DONE with result=0.
  - RUN: one iteration per cycle. After the DATA_WIDTH-th iteration, go to DONE.
  - DONE: done=1 for exactly this cycle. Next state is IDLE, unless start=1, in which case the new request is accepted as in IDLE (back-to-back).
- Latency:
  - start sampled at edge E0. busy=1 from E0 until E32.
  - After E32: DONE, done=1, busy=0. After E33: IDLE, done=0.
  - Fast paths (div-by-zero, illegal): done is high in the cycle immediately after E0; busy never asserts.
- start while in RUN is ignored; the in-flight operation is unaffected.
- ALU outputs:
  - In IDLE and DONE: alu_op1=0, alu_op2=0, alu_ctrl=000.
  - In RUN: driven as specified per algorithm below.
- Multiply (shift-add):
  - Registers: hi (DATA_WIDTH, init 0), lo (init rs1), mcand (rs2).
  - Each cycle: alu_op1=hi, alu_op2=mcand, alu_ctrl=000.
  - If lo[0]=1: carry = (alu_sum < hi, unsigned); {hi,lo} <= {carry, alu_sum, lo} >> 1.
  - Otherwise: {hi,lo} <= {1'b0, hi, lo} >> 1.
  - Result: MUL = lo, MULHU = hi (full 2*DATA_WIDTH-bit unsigned product).
- Divide (restoring):
  - Registers: rem (init 0), quo (init rs1), dvsr (rs2).
  - Each cycle: shifted = {rem, quo[MSB]}, a DATA_WIDTH+1-bit value; alu_op1 = shifted low DATA_WIDTH bits, alu_op2 = dvsr, alu_ctrl=001.
  - If shifted[MSB]=1 or alu_op1 >= dvsr: rem <= alu_sum, quo <= {quo<<1 | 1}.
  - Otherwise: rem <= alu_op1, quo <= quo<<1.
  - Result: DIVU = quo, REMU = rem.
- All arithmetic is unsigned and modulo 2^DATA_WIDTH, except the internal carry/MSB bits described above.
- result is updated only on the transition into DONE.

Test Plan:
- MUL rs1=7, rs2=6 -> busy for 32 cycles; done pulses 33 cycles after start; result=0x0000002A; then IDLE, result held.
- MULHU and MUL with rs1=rs2=0xFFFFFFFF -> MULHU result=0xFFFFFFFE, MUL result=0x00000001; alu_ctrl=000 throughout RUN.
- DIVU rs1=100, rs2=7 -> 14; REMU with the same operands -> 2; alu_ctrl=001 in RUN; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Divide by zero: DIVU rs1=0x1234, rs2=0 -> done in the next cycle, result=0xFFFFFFFF, busy never high; REMU -> 0x1234. Illegal funct3=010 -> result=0 after 1 cycle.
- start re-pulsed with different operands at cycle 10 of a MUL -> ignored; original product returned. start held high in DONE -> new op accepted; done pulses again 33 cycles later.
- rst_n low at cycle 15 of a DIVU -> busy=0, done=0, result=0 immediately (asynchronously); no done after release; a subsequent op completes correctly.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/response and shared-ALU signals between the core and the iterative
// multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_op2;
    logic [2:0]            alu_ctrl;
    logic [DATA_WIDTH-1:0] alu_sum;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    // Core side: issues requests and owns the ALU result wire.
    modport master (
        output start, funct3, rs1, rs2, alu_sum,
        input  alu_op1, alu_op2, alu_ctrl, busy, done, result
    );

    // Sequencer side.
    modport slave (
        input  start, funct3, rs1, rs2, alu_sum,
        output alu_op1, alu_op2, alu_ctrl, busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the core's
// shared ALU for its add (shift-add multiply) and subtract (restoring divide) steps.
module muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] F3_MUL   = 3'b000;
    localparam logic [2:0] F3_MULHU = 3'b011;
    localparam logic [2:0] F3_DIVU  = 3'b101;
    localparam logic [2:0] F3_REMU  = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // hi/lo double as rem/quo during a divide, mcand doubles as the divisor.
    logic [DATA_WIDTH-1:0] hi, lo, mcand;
    logic [DATA_WIDTH-1:0] hi_n, lo_n;
    logic [DATA_WIDTH-1:0] result_q;
    logic [CW-1:0]         counter;
    logic                  op_div;
    logic                  op_hi;

    logic                  load;
    logic                  fast;
    logic [DATA_WIDTH-1:0] fast_result;
    logic                  last;
    logic [DATA_WIDTH:0]   shifted;
    logic                  carry;

    assign last    = (counter == CW'(DATA_WIDTH - 1));
    assign shifted = {hi, lo[DATA_WIDTH-1]};
    assign carry   = (bus.alu_sum < hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        fast        = 1'b0;
        fast_result = '0;
        unique case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.start) begin
                    unique case (bus.funct3)
                        F3_MUL, F3_MULHU: begin
                            state_next = RUN;
                            load       = 1'b1;
                        end
                        F3_DIVU, F3_REMU: begin
                            if (bus.rs2 == '0) begin
                                state_next  = DONE;
                                fast        = 1'b1;
                                fast_result = bus.funct3[1] ? bus.rs1 : '1;
                            end else begin
                                state_next = RUN;
                                load       = 1'b1;
                            end
                        end
                        default: begin
                            state_next = DONE;
                            fast       = 1'b1;
                        end
                    endcase
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ALU steering and one-step next values for both algorithms.
    always_comb begin
        bus.alu_op1  = '0;
        bus.alu_op2  = '0;
        bus.alu_ctrl = ALU_ADD;
        hi_n         = hi;
        lo_n         = lo;
        if (state == RUN) begin
            if (op_div) begin
                bus.alu_op1  = shifted[DATA_WIDTH-1:0];
                bus.alu_op2  = mcand;
                bus.alu_ctrl = ALU_SUB;
                if (shifted[DATA_WIDTH] || (shifted[DATA_WIDTH-1:0] >= mcand)) begin
                    hi_n = bus.alu_sum;
                    lo_n = {lo[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    hi_n = shifted[DATA_WIDTH-1:0];
                    lo_n = {lo[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                bus.alu_op1  = hi;
                bus.alu_op2  = mcand;
                bus.alu_ctrl = ALU_ADD;
                if (lo[0]) begin
                    hi_n = {carry, bus.alu_sum[DATA_WIDTH-1:1]};
                    lo_n = {bus.alu_sum[0], lo[DATA_WIDTH-1:1]};
                end else begin
                    hi_n = {1'b0, hi[DATA_WIDTH-1:1]};
                    lo_n = {hi[0], lo[DATA_WIDTH-1:1]};
                end
            end
        end
    end

    // Operand latching, iteration and the result register (written only on entry to DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            counter  <= '0;
            op_div   <= 1'b0;
            op_hi    <= 1'b0;
            result_q <= '0;
        end else begin
            if (load) begin
                hi      <= '0;
                lo      <= bus.rs1;
                mcand   <= bus.rs2;
                counter <= '0;
                op_div  <= bus.funct3[2];
                op_hi   <= bus.funct3[1];
            end else if (state == RUN) begin
                hi      <= hi_n;
                lo      <= lo_n;
                counter <= counter + CW'(1);
            end

            if (fast) begin
                result_q <= fast_result;
            end else if ((state == RUN) && last) begin
                result_q <= op_hi ? hi_n : lo_n;
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule
